// File: rtl/ws_rec_buf.sv
// ws_rec_buf: double-buffered record collector between the jitter evaluators
// and the UDP framer. Records are packed Nr at a time into one of two banks;
// while one bank is being framed and sent, the other keeps filling.

module ws_rec_buf #(
    parameter int Nr = 4,
    parameter int Na = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rec_vld,
    input  logic [31:0]   rec_pcnt,
    input  logic [15:0]   rec_jtr1,
    input  logic [15:0]   rec_jtr2,
    input  logic          flush,
    input  logic          snd_rdy,
    input  logic [Na-1:0] addr,
    output logic [7:0]    payload,
    output logic          start,
    output logic [3:0]    fill_lvl,
    output logic [15:0]   ovf_cnt
);

    localparam logic [31:0] P_BYTES = 32'(2 + 8 * Nr);
    localparam logic [3:0]  NR_CNT  = 4'(Nr);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND
    } state_t;

    // Registered state; fill_sel_q = 0 means bank A fills and bank B is sent
    state_t      state_q, state_d;
    logic        fill_sel_q, fill_sel_d;
    logic [3:0]  cnt_a_q, cnt_a_d;
    logic [3:0]  cnt_b_q, cnt_b_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  frm_seq_q, frm_seq_d;
    logic        start_q, start_d;
    logic [15:0] ovf_q, ovf_d;

    // Record storage, word layout {jtr2, jtr1, pcnt}; stale words are hidden by the counts
    logic [63:0] mem_a [Nr];
    logic [63:0] mem_b [Nr];

    logic        wr_en;
    logic        wr_bank;
    logic [3:0]  wr_idx;
    logic [63:0] wr_data;
    logic [3:0]  new_cnt;

    logic [3:0]  fill_cnt;
    logic [3:0]  send_cnt;
    logic        swap;

    assign fill_cnt = fill_sel_q ? cnt_b_q : cnt_a_q;
    assign send_cnt = fill_sel_q ? cnt_a_q : cnt_b_q;
    assign swap     = (state_q == IDLE) &&
                      ((fill_cnt == NR_CNT) || (flush && (fill_cnt != 4'd0)));
    assign wr_data  = {rec_jtr2, rec_jtr1, rec_pcnt};

    // Next-state logic: send FSM, bank swap, record write and overflow counting
    always_comb begin
        state_d   = state_q;
        fill_sel_d = fill_sel_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        seq_d     = seq_q;
        frm_seq_d = frm_seq_q;
        start_d   = 1'b0;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        wr_bank   = fill_sel_q;
        wr_idx    = fill_cnt;
        new_cnt   = fill_cnt;

        case (state_q)
            IDLE:    if (swap) state_d = ARM;
            ARM:     if (!snd_rdy) state_d = SEND;
            SEND:    if (snd_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (swap) begin
            fill_sel_d = ~fill_sel_q;
            start_d    = 1'b1;
            frm_seq_d  = seq_q;
            seq_d      = seq_q + 8'd1;
            wr_bank    = ~fill_sel_q;
            wr_idx     = 4'd0;
            new_cnt    = 4'd0;
            if (rec_vld) begin
                wr_en   = 1'b1;
                new_cnt = 4'd1;
            end
        end else if (rec_vld) begin
            if (fill_cnt < NR_CNT) begin
                wr_en   = 1'b1;
                new_cnt = fill_cnt + 4'd1;
            end else if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end

        if (fill_sel_d) begin
            cnt_b_d = new_cnt;
        end else begin
            cnt_a_d = new_cnt;
        end
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fill_sel_q <= 1'b0;
            cnt_a_q    <= 4'd0;
            cnt_b_q    <= 4'd0;
            seq_q      <= 8'd0;
            frm_seq_q  <= 8'd0;
            start_q    <= 1'b0;
            ovf_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            fill_sel_q <= fill_sel_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            seq_q      <= seq_d;
            frm_seq_q  <= frm_seq_d;
            start_q    <= start_d;
            ovf_q      <= ovf_d;
        end
    end

    // Record RAM write port, no reset needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < Nr; i++) begin
            if (wr_en && !wr_bank && (wr_idx == 4'(i))) mem_a[i] <= wr_data;
            if (wr_en && wr_bank && (wr_idx == 4'(i)))  mem_b[i] <= wr_data;
        end
    end

    logic [31:0] addr_ext;
    logic [31:0] rec_off;
    logic [31:0] rec_k;
    logic [2:0]  byte_b;
    logic [63:0] sel_word;

    assign addr_ext = 32'(addr);
    assign rec_off  = addr_ext - 32'd2;
    assign rec_k    = {3'b000, rec_off[31:3]};
    assign byte_b   = rec_off[2:0];

    // Payload read mux over the send bank; records beyond the count read as zero
    always_comb begin
        sel_word = 64'd0;
        payload  = 8'd0;
        for (int i = 0; i < Nr; i++) begin
            if ((rec_k == 32'(i)) && (4'(i) < send_cnt)) begin
                sel_word = fill_sel_q ? mem_a[i] : mem_b[i];
            end
        end
        if (addr_ext == 32'd0) begin
            payload = frm_seq_q;
        end else if (addr_ext == 32'd1) begin
            payload = {4'd0, send_cnt};
        end else if (addr_ext < P_BYTES) begin
            payload = sel_word[{byte_b, 3'b000} +: 8];
        end
    end

    assign start    = start_q;
    assign fill_lvl = fill_cnt;
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_ws_rec_buf.sv
// tb_ws_rec_buf: self-checking bench for ws_rec_buf. A queue-based model of
// the record collector runs alongside the DUT and a compare process checks
// start, fill_lvl, ovf_cnt and payload every cycle; directed scenarios pin
// the model with literal expectations, then randomized traffic follows.

module tb_ws_rec_buf;

    localparam int NR = 4;
    localparam int NA = 6;
    localparam int P  = 2 + 8 * NR;

    logic          clk;
    logic          rst_n;
    logic          rec_vld;
    logic [31:0]   rec_pcnt;
    logic [15:0]   rec_jtr1;
    logic [15:0]   rec_jtr2;
    logic          flush;
    logic          snd_rdy;
    logic [NA-1:0] addr;
    logic [7:0]    payload;
    logic          start;
    logic [3:0]    fill_lvl;
    logic [15:0]   ovf_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    ws_rec_buf #(.Nr(NR), .Na(NA)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rec_vld  (rec_vld),
        .rec_pcnt (rec_pcnt),
        .rec_jtr1 (rec_jtr1),
        .rec_jtr2 (rec_jtr2),
        .flush    (flush),
        .snd_rdy  (snd_rdy),
        .addr     (addr),
        .payload  (payload),
        .start    (start),
        .fill_lvl (fill_lvl),
        .ovf_cnt  (ovf_cnt)
    );

    // 50 MHz clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: records waiting to be sent, the frozen frame being sent,
    // and a busy phase (0 idle, 1 armed, 2 sending) following the framer handshake
    typedef struct {
        logic [31:0] pcnt;
        logic [15:0] j1;
        logic [15:0] j2;
    } rec_t;

    rec_t        fill_q[$];
    rec_t        snd_r[$];
    logic [7:0]  m_seq;
    logic [7:0]  m_snd_seq;
    int          m_phase;
    bit          m_start;
    int          m_ovf;
    bit          m_swapped;

    function automatic logic [7:0] exp_payload(int a);
        int k;
        int b;
        rec_t r;
        if (a == 0) return m_snd_seq;
        if (a == 1) return 8'(snd_r.size());
        if (a >= P) return 8'd0;
        k = (a - 2) / 8;
        b = (a - 2) % 8;
        if (k >= snd_r.size()) return 8'd0;
        r = snd_r[k];
        case (b)
            0: return r.pcnt[7:0];
            1: return r.pcnt[15:8];
            2: return r.pcnt[23:16];
            3: return r.pcnt[31:24];
            4: return r.j1[7:0];
            5: return r.j1[15:8];
            6: return r.j2[7:0];
            default: return r.j2[15:8];
        endcase
    endfunction

    // Model update on each clock edge, cleared asynchronously by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q.delete();
            snd_r.delete();
            m_seq     = 8'd0;
            m_snd_seq = 8'd0;
            m_phase   = 0;
            m_start   = 1'b0;
            m_ovf     = 0;
            m_swapped = 1'b0;
        end else begin
            int sz;
            bit sw;
            rec_t r;
            sz = fill_q.size();
            sw = (m_phase == 0) && ((sz == NR) || (flush && (sz > 0)));
            m_start = sw;
            if (m_phase == 1 && !snd_rdy) m_phase = 2;
            else if (m_phase == 2 && snd_rdy) m_phase = 0;
            if (sw) begin
                snd_r     = fill_q;
                m_snd_seq = m_seq;
                m_seq     = m_seq + 8'd1;
                fill_q.delete();
                m_phase   = 1;
                m_swapped = 1'b1;
            end
            if (rec_vld) begin
                if (sw || (sz < NR)) begin
                    r.pcnt = rec_pcnt;
                    r.j1   = rec_jtr1;
                    r.j2   = rec_jtr2;
                    fill_q.push_back(r);
                end else if (m_ovf < 65535) begin
                    m_ovf = m_ovf + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("start", 32'(start), 32'(m_start));
            checkOutput("fill_lvl", 32'(fill_lvl), 32'(fill_q.size()));
            checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            if (m_phase != 0 || !m_swapped) begin
                checkOutput("payload", 32'(payload), 32'(exp_payload(int'(addr))));
            end
        end
    end

    // Drive one cycle of inputs, then step to just after the next rising edge
    task automatic applyStimulus(input logic vld, input logic [31:0] pc, input logic [15:0] j1,
                                 input logic [15:0] j2, input logic fl, input logic rdy, input int a);
        rec_vld  = vld;
        rec_pcnt = pc;
        rec_jtr1 = j1;
        rec_jtr2 = j2;
        flush    = fl;
        snd_rdy  = rdy;
        addr     = NA'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int a);
        applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 1'b0, rdy, a);
    endtask

    // Safety net against a hung run
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic
    initial begin
        rst_n = 1'b0;
        rec_vld = 1'b0; rec_pcnt = '0; rec_jtr1 = '0; rec_jtr2 = '0;
        flush = 1'b0; snd_rdy = 1'b1; addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_fill_lvl", 32'(fill_lvl), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_cnt), 32'd0);
        checkOutput("rst_payload0", 32'(payload), 32'd0);
        rst_n = 1'b1;

        // Four records fill the bank and trigger an automatic frame
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 16'h0A0B, 16'h0C0D, 1'b0, 1'b1, 0);
        checkOutput("t1_fill4", 32'(fill_lvl), 32'd4);
        checkOutput("t1_nostart", 32'(start), 32'd0);
        idle(1'b1, 0);
        checkOutput("t1_start", 32'(start), 32'd1);
        checkOutput("t1_byte0", 32'(payload), 32'h00);
        idle(1'b1, 1);
        checkOutput("t1_start_once", 32'(start), 32'd0);
        checkOutput("t1_byte1", 32'(payload), 32'h04);
        idle(1'b1, 2);  checkOutput("t1_byte2", 32'(payload), 32'h01);
        idle(1'b1, 6);  checkOutput("t1_byte6", 32'(payload), 32'h0B);
        idle(1'b1, 9);  checkOutput("t1_byte9", 32'(payload), 32'h0C);
        idle(1'b1, 34); checkOutput("t1_byte34", 32'(payload), 32'h00);
        idle(1'b0, 0);
        idle(1'b1, 0);

        // Partial frame sent by flush
        applyStimulus(1'b1, 32'h11223344, 16'h5566, 16'h7788, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 32'h99AABBCC, 16'hDDEE, 16'hFF01, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1);
        checkOutput("t2_start", 32'(start), 32'd1);
        checkOutput("t2_byte1", 32'(payload), 32'h02);
        for (int a = 18; a <= 33; a++) begin
            idle(1'b1, a);
            checkOutput("t2_empty_rec", 32'(payload), 32'h00);
        end
        idle(1'b1, 0);  checkOutput("t2_byte0", 32'(payload), 32'h01);
        idle(1'b1, 2);  checkOutput("t2_byte2", 32'(payload), 32'h44);
        idle(1'b1, 17); checkOutput("t2_byte17", 32'(payload), 32'hFF);
        idle(1'b0, 0);
        idle(1'b1, 0);

        // Fill while the framer is busy, then overflow
        applyStimulus(1'b1, 32'hA5A50001, 16'h1111, 16'h2222, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(16 + i), 16'h3333, 16'h4444, 1'b0, 1'b0, 0);
        checkOutput("t3_fill4", 32'(fill_lvl), 32'd4);
        checkOutput("t3_nostart", 32'(start), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32 + i), 16'h5555, 16'h6666, 1'b0, 1'b0, 0);
        checkOutput("t3_ovf3", 32'(ovf_cnt), 32'd3);
        checkOutput("t3_fill_hold", 32'(fill_lvl), 32'd4);
        idle(1'b1, 0);
        checkOutput("t3_nostart_yet", 32'(start), 32'd0);

        // Record arriving in the swap cycle lands in the new fill bank
        applyStimulus(1'b1, 32'h0000BEEF, 16'h7777, 16'h8888, 1'b0, 1'b1, 1);
        checkOutput("t4_start", 32'(start), 32'd1);
        checkOutput("t4_fill1", 32'(fill_lvl), 32'd1);
        checkOutput("t4_count4", 32'(payload), 32'h04);
        checkOutput("t4_ovf_keep", 32'(ovf_cnt), 32'd3);

        // Reset in the middle of a send
        idle(1'b0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_start", 32'(start), 32'd0);
        checkOutput("t5_ovf", 32'(ovf_cnt), 32'd0);
        checkOutput("t5_fill", 32'(fill_lvl), 32'd0);
        for (int a = 0; a < 64; a++) begin
            addr = NA'(a);
            #1;
            checkOutput("t5_payload", 32'(payload), 32'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h101 + 32'(i), 16'h0102, 16'h0304, 1'b0, 1'b1, 0);
        idle(1'b1, 0);
        checkOutput("t5_start_after", 32'(start), 32'd1);
        checkOutput("t5_seq0", 32'(payload), 32'h00);
        idle(1'b1, 2);
        checkOutput("t5_byte2", 32'(payload), 32'h01);
        idle(1'b0, 0);
        idle(1'b1, 0);

        // 257 frames from a fresh reset: sequence number wraps
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int f = 0; f <= 256; f++) begin
            applyStimulus(1'b1, 32'(f), 16'(f), ~16'(f), 1'b0, 1'b1, 0);
            applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 1'b1, 1'b1, 0);
            if (f == 255) checkOutput("t6_seq255", 32'(payload), 32'hFF);
            if (f == 256) checkOutput("t6_seq_wrap", 32'(payload), 32'h00);
            idle(1'b0, 0);
            idle(1'b1, 0);
        end

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 63)));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ws_rec_buf.md
Name: ws_rec_buf

Overview:
Double-buffered record collector that sits between the jitter evaluators (ws_log_max outputs plus the measurement counter) and the UDP framer (udp_send).
- Packs Nr measurement records into one UDP payload, so frames go out Nr times less often.
- Serves payload bytes to the framer by byte address.
- Keeps accepting new records while the previous frame is still being transmitted.

Parameters:
Nr, 4, records per frame (1..15)
Na, 6, payload byte-address width; must satisfy 2^Na >= P, where P = 2+8*Nr (34 at default)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous reset, active-low
rec_vld  in  1  single-cycle strobe: record inputs are valid
rec_pcnt  in  32  measurement counter value
rec_jtr1  in  16  channel 1 worst-case jitter
rec_jtr2  in  16  channel 2 worst-case jitter
flush  in  1  single-cycle strobe: send the partially filled bank
snd_rdy  in  1  framer idle level (udp_send rdy)
addr  in  Na  payload byte index requested by the framer
payload  out  8  payload byte at addr, from the bank being sent; combinational from addr and registered state
start  out  1  single-cycle frame-start pulse to the framer
fill_lvl  out  4  records held in the fill bank
ovf_cnt  out  16  dropped-record counter, saturating at 16'hFFFF

Behaviour:
Reset (rst_n=0, asynchronous, allowed at any time including mid-frame):
- Both bank counts = 0, fill bank = A, state IDLE, seq = 0.
- start = 0, fill_lvl = 0, ovf_cnt = 0.
- payload reads 0 for every addr.
- Record RAM contents need no reset, because count-masking hides them.

Storage:
- Two banks A and B, each Nr x 64 bits plus a count register.
- Record word layout: {jtr2, jtr1, pcnt}.

Payload layout for the send bank, P bytes:
- byte0 = seq of this frame.
- byte1 = record count of this frame.
- byte 2+8k .. 9+8k = record k, little-endian: pcnt[7:0] first, then pcnt bytes, jtr1 low, jtr1 high, jtr2 low, jtr2 high.
- Records with k >= count read as 0.
- addr >= P reads as 0.

Fill side:
- rec_vld with fill count < Nr and no swap this cycle: write at index count, count+1 on the next edge.
- rec_vld with fill count == Nr and no swap this cycle: record dropped, ovf_cnt+1 (saturating).

Swap condition (evaluated on registered values):
- Trigger: (fill count == Nr, or flush with fill count > 0) and state == IDLE.
- On the swap edge:
  - fill and send roles exchange.
  - The new fill bank count is cleared.
  - start = 1 for exactly that one cycle; seq for the outgoing frame is the current seq.
  - seq increments after start, wrapping 255 -> 0.
- rec_vld in the swap cycle goes to the new fill bank at index 0, so its count becomes 1.
- flush with fill count == 0: ignored.
- flush while state != IDLE: ignored, not remembered.
- A full bank waiting for IDLE swaps automatically once IDLE is reached.

Send FSM:
- IDLE -> ARM on swap.
- ARM -> SEND when snd_rdy == 0.
- SEND -> IDLE when snd_rdy == 1.
- Send-bank contents and count are frozen from swap until return to IDLE.
- payload stays valid for any addr throughout ARM and SEND.
- Minimum one cycle in ARM, even if snd_rdy is already 0.

fill_lvl tracks the registered fill count; latency from rec_vld is 1 cycle.

Test Plan:
1. Reset release, 4 rec_vld with pcnt = 1..4, jtr1 = 16'h0A0B, jtr2 = 16'h0C0D:
   - one start pulse the cycle after the 4th record has registered;
   - addr 0 -> 8'h00, addr 1 -> 8'h04, addr 2 -> 8'h01, addr 6 -> 8'h0B, addr 9 -> 8'h0C, addr 34 -> 8'h00.
2. 2 records, then flush:
   - start pulse; byte1 = 2; addr 18..33 read 0;
   - seq increments, so byte0 of the next frame = 8'h01.
3. Hold snd_rdy = 0 after start, push 4 more records, then 3 further records:
   - 4 records fill the bank, fill_lvl = 4, no start;
   - the 3 further records give ovf_cnt = 3;
   - after snd_rdy returns to 1, an automatic swap and start follow.
4. rec_vld in the same cycle as a swap:
   - the record lands at index 0 of the new fill bank, fill_lvl = 1;
   - the outgoing frame's count = 4.
5. Assert rst_n = 0 during SEND:
   - start = 0, payload = 0 for all addr, ovf_cnt = 0;
   - after release, the first frame carries seq = 0.
6. Send 256 frames:
   - the 257th frame carries byte0 = 8'h00 (wrap).
